// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- multi-cycle RV32I control sequencer.
//
// Steps every instruction through FETCH, DECODE, EXEC, MEM and WB using the
// 4-bit class from the instruction decoder, and drives the PC, IR,
// register-file, ALU-operand and shared memory-port strobes. The memory port
// may stretch any access with wait states; the request is held until
// mem_ready is seen.
//
// Optional feature macro: CTRL_PERF_CNT_EN adds free-running cycle and
// retired-instruction counters (cycle_cnt, instret_cnt).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instType        decoder class (0 load .. 8 jal, 9-15 illegal)
//   branch_taken    ALU compare result, consulted in EXEC only
//   mem_ready       memory completes the outstanding request this cycle
//   mem_req/mem_we  memory request and its write qualifier
//   mem_addr_sel    0 = PC, 1 = ALU result
//   ir_we, pc_we    instruction-register load, PC update
//   pc_src          0 PC+4, 1 PC+imm, 2 {ALU[31:1],0}
//   rf_we, wb_sel   register-file write, write-back source
//   alu_src_a/b     ALU operand muxes (PC / immediate when 1)
//   illegal, retire one-cycle status pulses
//   cycle_cnt, instret_cnt  (CTRL_PERF_CNT_EN only) 32-bit wrapping counters
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  instType,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        illegal,
  output logic        retire
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [3:0] T_LOAD  = 4'd0;
  localparam logic [3:0] T_IMM   = 4'd1;
  localparam logic [3:0] T_STORE = 4'd2;
  localparam logic [3:0] T_REG   = 4'd3;
  localparam logic [3:0] T_LUI   = 4'd4;
  localparam logic [3:0] T_AUIPC = 4'd5;
  localparam logic [3:0] T_BR    = 4'd6;
  localparam logic [3:0] T_JALR  = 4'd7;
  localparam logic [3:0] T_JAL   = 4'd8;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t     state, nxt;
  logic [3:0] type_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      type_q <= 4'd0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) type_q <= instType;
    end
  end

  // Outputs are forced low while rst is high, so a request in flight is
  // dropped in the reset cycle itself rather than one cycle later.
  always_comb begin
    nxt          = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    illegal      = 1'b0;
    retire       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            nxt   = S_DECODE;
          end
        end
        S_DECODE: begin
          if (instType > T_JAL) begin
            // Skip the bad instruction: advance PC, no retire.
            illegal = 1'b1;
            pc_we   = 1'b1;
            nxt     = S_FETCH;
          end else begin
            nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src_a = (type_q == T_AUIPC);
          alu_src_b = !((type_q == T_REG) || (type_q == T_BR));
          case (type_q)
            T_LOAD, T_STORE: nxt = S_MEM;
            T_BR: begin
              pc_we  = 1'b1;
              pc_src = branch_taken ? 2'd1 : 2'd0;
              retire = 1'b1;
              nxt    = S_FETCH;
            end
            T_IMM, T_REG, T_LUI, T_AUIPC, T_JALR, T_JAL: nxt = S_WB;
            default: nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (type_q == T_STORE);
          if (mem_ready) begin
            if (type_q == T_STORE) begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = S_FETCH;
            end else begin
              nxt = S_WB;
            end
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          nxt    = S_FETCH;
          case (type_q)
            T_LOAD:       wb_sel = 2'd1;
            T_LUI:        wb_sel = 2'd3;
            T_JAL, T_JALR: wb_sel = 2'd2;
            default:      wb_sel = 2'd0;
          endcase
          case (type_q)
            T_JAL:   pc_src = 2'd1;
            T_JALR:  pc_src = 2'd2;
            default: pc_src = 2'd0;
          endcase
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm. Each driven cycle pushes the expected output vector
// onto a queue; a negedge monitor pops and compares against the DUT.
// Vector layout: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src[1:0],
//                 rf_we, wb_sel[1:0], alu_src_a, alu_src_b, illegal, retire}
module tb_ctrl_fsm;
  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [3:0]  instType = 4'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic [1:0]  pc_src, wb_sel;
  logic        alu_src_a, alu_src_b, illegal, retire;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int total = 0;
  int bad = 0;
  int n_cyc = 0;
  int n_ret = 0;
  string cur_tag = "reset";
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .instType(instType), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .illegal(illegal),
    .retire(retire)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  wire [13:0] got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                     rf_we, wb_sel, alu_src_a, alu_src_b, illegal, retire};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      chk(cur_tag, {18'd0, got}, {18'd0, e});
    end
  end

  function automatic logic [13:0] v(input logic req, we, asel, ir, pcw,
                                    input logic [1:0] pcs, input logic rf,
                                    input logic [1:0] wb, input logic a, b, ill, ret);
    return {req, we, asel, ir, pcw, pcs, rf, wb, a, b, ill, ret};
  endfunction

  // Drive one cycle and queue its expected outputs.
  task automatic cyc(input logic r, rdy, input logic [3:0] it, input logic bt,
                     input logic [13:0] e);
    rst = r; mem_ready = rdy; instType = it; branch_taken = bt;
    exp_q.push_back(e);
    if (r) begin n_cyc = 0; n_ret = 0; end
    else begin n_cyc++; n_ret += int'(e[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic perf_chk();
`ifdef CTRL_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, n_cyc);
    chk("instret_cnt", instret_cnt, n_ret);
`endif
  endtask

  // One instruction: fw/mw wait states on fetch/data access. Outside DECODE
  // instType carries junk so that only the captured class can matter.
  task automatic run_instr(input string nm, input logic [3:0] it, input logic bt,
                           input int fw, input int mw);
    logic a, b, st;
    logic [1:0] wb, pcs;
    cur_tag = nm;
    for (int i = 0; i < fw; i++) cyc(0, 0, 4'hd, 0, v(1,0,0,0,0,2'd0,0,2'd0,0,0,0,0));
    cyc(0, 1, 4'hd, 0, v(1,0,0,1,0,2'd0,0,2'd0,0,0,0,0));
    if (it > 4'd8) begin
      cyc(0, 1, it, 0, v(0,0,0,0,1,2'd0,0,2'd0,0,0,1,0));
      return;
    end
    cyc(0, 1, it, 0, 14'd0);
    a = (it == 4'd5);
    b = !(it == 4'd3 || it == 4'd6);
    if (it == 4'd6) begin
      cyc(0, 1, 4'hf, bt, v(0,0,0,0,1,{1'b0,bt},0,2'd0,a,b,0,1));
      return;
    end
    cyc(0, 1, 4'hf, bt, v(0,0,0,0,0,2'd0,0,2'd0,a,b,0,0));
    if (it == 4'd0 || it == 4'd2) begin
      st = (it == 4'd2);
      for (int i = 0; i < mw; i++) cyc(0, 0, 4'hf, 0, v(1,st,1,0,0,2'd0,0,2'd0,0,0,0,0));
      cyc(0, 1, 4'hf, 0, v(1,st,1,0,st,2'd0,0,2'd0,0,0,0,st));
      if (st) return;
    end
    wb  = (it == 4'd0) ? 2'd1 : (it == 4'd4) ? 2'd3 :
          (it == 4'd7 || it == 4'd8) ? 2'd2 : 2'd0;
    pcs = (it == 4'd8) ? 2'd1 : (it == 4'd7) ? 2'd2 : 2'd0;
    cyc(0, 1, 4'hf, 0, v(0,0,0,0,1,pcs,1,wb,0,0,0,1));
  endtask

  initial begin
    cyc(1, 1, 4'd0, 0, 14'd0);
    cyc(1, 0, 4'd3, 1, 14'd0);
    perf_chk();
    run_instr("reg", 4'd3, 0, 0, 0);
    run_instr("load_ws2", 4'd0, 0, 0, 2);
    run_instr("br_taken", 4'd6, 1, 0, 0);
    run_instr("br_not", 4'd6, 0, 0, 0);
    run_instr("store", 4'd2, 0, 0, 1);
    run_instr("jalr", 4'd7, 1, 0, 0);
    run_instr("imm", 4'd1, 1, 1, 0);
    run_instr("lui", 4'd4, 0, 0, 0);
    run_instr("auipc", 4'd5, 1, 0, 0);
    run_instr("jal", 4'd8, 0, 2, 0);
    run_instr("illegal12", 4'd12, 0, 0, 0);
    run_instr("illegal9", 4'd9, 0, 1, 0);
    run_instr("load_fw", 4'd0, 0, 3, 0);
    perf_chk();
    // Reset while fetch is waiting: outputs low that cycle, FETCH after.
    cur_tag = "rst_fetch";
    cyc(0, 0, 4'hd, 0, v(1,0,0,0,0,2'd0,0,2'd0,0,0,0,0));
    cyc(1, 1, 4'hd, 0, 14'd0);
    perf_chk();
    run_instr("post_rst_reg", 4'd3, 0, 0, 0);
    run_instr("post_rst_st", 4'd2, 0, 0, 0);
    run_instr("post_rst_br", 4'd6, 1, 0, 0);
    perf_chk();
`ifdef CTRL_PERF_CNT_EN
    chk("instret_3", instret_cnt, 32'd3);
`endif
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
